// File: rtl/sd_cmd_phys.sv
// SD card CMD-line PHY: serialises a command with CRC7, waits for and
// captures the short or long response, and reports CRC/timeout status.
module sd_cmd_phys #(
    parameter int CMD_W       = 48,
    parameter int RSP_SHORT_W = 48,
    parameter int RSP_LONG_W  = 136,
    parameter int TIMEOUT     = 64
) (
    input  logic                  sd_clock,
    input  logic                  reset,
    input  logic                  strobe_in,
    input  logic                  ack_in,
    input  logic                  idle_in,
    input  logic [CMD_W-9:0]      cmd_to_send,
    input  logic [1:0]            rsp_type,
    input  logic                  crc_chk_en,
    output logic                  ack_out,
    output logic                  strobe_out,
    output logic [RSP_LONG_W-1:0] response,
    output logic                  crc_err,
    output logic                  timeout_err,
    output logic                  cmd_out,
    output logic                  cmd_oe,
    input  logic                  cmd_in
);

    localparam int MAX_W = (RSP_LONG_W > CMD_W) ? RSP_LONG_W : CMD_W;
    localparam int BW    = $clog2(MAX_W + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [BW-1:0] CMD_LAST      = BW'(CMD_W - 1);
    localparam logic [BW-1:0] CRC_FIRST     = BW'(CMD_W - 8);
    localparam logic [BW-1:0] SHORT_LAST    = BW'(RSP_SHORT_W);
    localparam logic [BW-1:0] LONG_LAST     = BW'(RSP_LONG_W);
    localparam logic [BW-1:0] SHORT_CRC_END = BW'(RSP_SHORT_W - 8);
    localparam logic [BW-1:0] LONG_CRC_END  = BW'(RSP_LONG_W - 8);
    localparam logic [BW-1:0] LONG_CRC_BEG  = BW'(9);
    localparam logic [TW-1:0] TIMEOUT_M1    = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WAIT_RSP = 3'd2,
        ST_RECV     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    // One serial CRC7 step, polynomial x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    state_t          state_r;
    logic [CMD_W-9:0] tx_r;
    logic [6:0]      crc_r;
    logic [BW-1:0]   bit_cnt_r;
    logic [TW-1:0]   wait_cnt_r;
    logic            long_r;
    logic            none_r;
    logic            chk_en_r;

    logic [BW-1:0]   bit_nxt_s;
    logic [6:0]      crc_tx_s;
    logic [6:0]      crc_rx_s;
    logic [BW-1:0]   frame_last_s;
    logic            rx_in_crc_s;

    // Next bit index, CRC candidates and the receive-frame window.
    always_comb begin
        bit_nxt_s = bit_cnt_r + BW'(1);
        crc_tx_s  = crc7_step(crc_r, cmd_out);
        crc_rx_s  = crc7_step(crc_r, cmd_in);
        if (long_r) begin
            frame_last_s = LONG_LAST;
            rx_in_crc_s  = (bit_nxt_s >= LONG_CRC_BEG) && (bit_nxt_s <= LONG_CRC_END);
        end else begin
            frame_last_s = SHORT_LAST;
            rx_in_crc_s  = (bit_nxt_s <= SHORT_CRC_END);
        end
    end

    // Main controller: state, counters, CRC, pad drive and host handshake.
    always_ff @(posedge sd_clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            tx_r        <= '0;
            crc_r       <= 7'd0;
            bit_cnt_r   <= '0;
            wait_cnt_r  <= '0;
            long_r      <= 1'b0;
            none_r      <= 1'b0;
            chk_en_r    <= 1'b0;
            ack_out     <= 1'b0;
            strobe_out  <= 1'b0;
            response    <= '0;
            crc_err     <= 1'b0;
            timeout_err <= 1'b0;
            cmd_out     <= 1'b1;
            cmd_oe      <= 1'b0;
        end else begin
            ack_out <= 1'b0;
            if (idle_in) begin
                state_r    <= ST_IDLE;
                strobe_out <= 1'b0;
                cmd_oe     <= 1'b0;
                cmd_out    <= 1'b1;
                bit_cnt_r  <= '0;
                wait_cnt_r <= '0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        cmd_oe  <= 1'b0;
                        cmd_out <= 1'b1;
                        if (strobe_in) begin
                            tx_r        <= cmd_to_send;
                            long_r      <= (rsp_type == 2'b10);
                            none_r      <= (rsp_type == 2'b00);
                            chk_en_r    <= crc_chk_en;
                            ack_out     <= 1'b1;
                            crc_err     <= 1'b0;
                            timeout_err <= 1'b0;
                            crc_r       <= 7'd0;
                            bit_cnt_r   <= '0;
                            cmd_oe      <= 1'b1;
                            cmd_out     <= cmd_to_send[CMD_W-9];
                            state_r     <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (bit_cnt_r == CMD_LAST) begin
                            cmd_oe     <= 1'b0;
                            cmd_out    <= 1'b1;
                            bit_cnt_r  <= '0;
                            wait_cnt_r <= '0;
                            if (none_r) begin
                                strobe_out <= 1'b1;
                                state_r    <= ST_DONE;
                            end else begin
                                state_r <= ST_WAIT_RSP;
                            end
                        end else begin
                            bit_cnt_r <= bit_nxt_s;
                            if (bit_nxt_s < CRC_FIRST) begin
                                crc_r   <= crc_tx_s;
                                cmd_out <= tx_r[CMD_W-10];
                                tx_r    <= {tx_r[CMD_W-10:0], 1'b0};
                            end else if (bit_nxt_s == CRC_FIRST) begin
                                // Last data bit is on the line now; fold it in and emit CRC MSB.
                                crc_r   <= crc_tx_s;
                                cmd_out <= crc_tx_s[6];
                            end else if (bit_nxt_s != CMD_LAST) begin
                                crc_r   <= {crc_r[5:0], 1'b0};
                                cmd_out <= crc_r[5];
                            end else begin
                                cmd_out <= 1'b1;
                            end
                        end
                    end
                    ST_WAIT_RSP: begin
                        if (!cmd_in) begin
                            // Start bit is frame bit 1; a leading zero leaves CRC at zero.
                            response  <= '0;
                            crc_r     <= 7'd0;
                            bit_cnt_r <= BW'(1);
                            state_r   <= ST_RECV;
                        end else if (wait_cnt_r == TIMEOUT_M1) begin
                            wait_cnt_r  <= wait_cnt_r + TW'(1);
                            timeout_err <= 1'b1;
                            strobe_out  <= 1'b1;
                            state_r     <= ST_DONE;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + TW'(1);
                        end
                    end
                    ST_RECV: begin
                        response  <= {response[RSP_LONG_W-2:0], cmd_in};
                        bit_cnt_r <= bit_nxt_s;
                        if (rx_in_crc_s) begin
                            crc_r <= crc_rx_s;
                        end else begin
                            crc_r <= crc_r;
                        end
                        if (bit_nxt_s == frame_last_s) begin
                            // response[6:0] currently holds frame bits [7:1].
                            crc_err    <= chk_en_r && (crc_r != response[6:0]);
                            strobe_out <= 1'b1;
                            bit_cnt_r  <= '0;
                            state_r    <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        if (ack_in) begin
                            strobe_out <= 1'b0;
                            state_r    <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        strobe_out <= 1'b0;
                        cmd_oe     <= 1'b0;
                        cmd_out    <= 1'b1;
                        bit_cnt_r  <= '0;
                        wait_cnt_r <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sd_cmd_phys.md
SD_CMD_PHYS -- requirements
Module: sd_cmd_phys

Interface
REQ-001 Parameter CMD_W, default 48; command frame length in bits.
REQ-002 Parameter RSP_SHORT_W, default 48; short-response (R1/R3/R6/R7) frame length.
REQ-003 Parameter RSP_LONG_W, default 136; long-response (R2) frame length.
REQ-004 Parameter TIMEOUT, default 64; maximum sd_clock cycles from command end bit to response start bit.
REQ-005 Port sd_clock  in  1  the only clock; all state changes on its rising edge.
REQ-006 Port reset  in  1  asynchronous, active-high reset.
REQ-007 Port strobe_in  in  1  host request to send cmd_to_send.
REQ-008 Port ack_in  in  1  host acknowledges the response or status held in DONE.
REQ-009 Port idle_in  in  1  synchronous abort; forces IDLE.
REQ-010 Port cmd_to_send  in  CMD_W-8  start, transmission, index and argument bits; MSB is sent first.
REQ-011 Port rsp_type  in  2  00 none, 01 short, 10 long, 11 treated as short; sampled at strobe_in.
REQ-012 Port crc_chk_en  in  1  1 enables response CRC check (0 for R3); sampled at strobe_in.
REQ-013 Port ack_out  out  1  one-cycle pulse confirming the command was latched.
REQ-014 Port strobe_out  out  1  response or status available; held until ack_in.
REQ-015 Port response  out  RSP_LONG_W  received frame, right-aligned; short frames zero-extended.
REQ-016 Port crc_err  out  1  response CRC7 mismatch; valid while strobe_out=1.
REQ-017 Port timeout_err  out  1  no start bit within TIMEOUT; valid while strobe_out=1.
REQ-018 Ports cmd_out, cmd_oe  out  1 each  pad drive value and output enable.
REQ-019 Port cmd_in  in  1  pad sampled value.

Function
REQ-020 States: IDLE, SEND, WAIT_RSP, RECV, DONE; encoding is free.
REQ-021 IDLE: cmd_oe=0, cmd_out=1. On strobe_in=1: latch cmd_to_send, rsp_type and crc_chk_en; pulse ack_out for 1 cycle; clear crc_err and timeout_err; next state SEND.
REQ-022 SEND: cmd_oe=1, one bit per cycle, MSB first, CMD_W cycles total. The first CMD_W-8 bits are the latched command, the next 7 are CRC7, and the last bit is the end bit 1.
REQ-023 CRC7: polynomial x^7+x^3+1, initial value 0, computed serially over the first CMD_W-8 transmitted bits.
REQ-024 The cycle after the end bit: if rsp_type=00 go to DONE, else go to WAIT_RSP with the wait counter at 0.
REQ-025 WAIT_RSP: cmd_oe=0. cmd_in=0 is the start bit; the next state is RECV and that bit counts as received bit 1. Otherwise increment the counter; when the counter reaches TIMEOUT with no start bit, set timeout_err=1 and go to DONE.
REQ-026 RECV: shift cmd_in into response LSB-first-in, so the first bit ends in the MSB of the frame. Total frame is RSP_SHORT_W or RSP_LONG_W bits including the start bit. After the last bit, go to DONE.
REQ-027 Response CRC, short frame: computed over frame bits [RSP_SHORT_W-1:8] and compared with bits [7:1].
REQ-028 Response CRC, long frame: computed over bits [RSP_LONG_W-9:8] and compared with bits [7:1]; the 8-bit header is excluded.
REQ-029 crc_err=1 on a CRC mismatch only if crc_chk_en=1.
REQ-030 DONE: strobe_out=1; response, crc_err and timeout_err are stable. ack_in=1 returns to IDLE the next cycle with strobe_out=0.
REQ-031 idle_in=1 in any state: next state IDLE, cmd_oe=0, strobe_out=0; response contents are kept. idle_in has priority over strobe_in and ack_in in the same cycle.
REQ-032 strobe_in outside IDLE is ignored; no ack_out is generated.
REQ-033 A start bit in the same cycle the counter reaches TIMEOUT is accepted; there is no timeout.
REQ-034 The response register is cleared to 0 at RECV entry, so no bits from a previous response remain.
REQ-035 All bit and wait counters are sized from $clog2 of their maximum count and never wrap within a frame.

Reset
REQ-036 reset=1 immediately forces, independent of sd_clock: state IDLE, ack_out=0, strobe_out=0, response=0, crc_err=0, timeout_err=0, cmd_oe=0, cmd_out=1, all counters 0.
REQ-037 Reset asserted mid-SEND or mid-RECV aborts with no strobe_out. The first command after reset release is handled normally.

Verification
REQ-038 CMD0: cmd_to_send=40'h4000000000, rsp_type=00 -> cmd_out serialises 48'h400000000095 over 48 cycles with cmd_oe=1, then DONE with strobe_out=1 and no errors.
REQ-039 CMD8: cmd_to_send=40'h48000001AA, rsp_type=01; pad returns 48'h08000001AA13 5 cycles after the end bit -> response[47:0]=48'h08000001AA13, crc_err=0 (or drive the CRC7-correct tail computed by the reference model).
REQ-040 Same CMD8 with response bit 3 flipped and crc_chk_en=1 -> crc_err=1. The same corrupted frame with crc_chk_en=0 -> crc_err=0.
REQ-041 rsp_type=01 with cmd_in held at 1 -> timeout_err=1 and strobe_out rises TIMEOUT+1 cycles after the end bit. Start bit driven at exactly TIMEOUT -> accepted.
REQ-042 rsp_type=10 with a 136-bit R2 frame -> the full frame lands in response[135:0] and the CRC is checked over bits [127:8].
REQ-043 idle_in pulse in mid-SEND, and async reset in mid-RECV -> cmd_oe=0 the next edge (immediately for reset) and no strobe_out. A follow-up CMD0 then completes correctly.
